// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Control FSM for a shared-datapath multicycle MIPS core (one memory, one
//   ALU, IR/PC/ALUOut/MDR registers). Control outputs are decoded from the
//   current state, with Op/Funct/mem_ready qualifying them where needed.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   Op, Funct           IR opcode / funct fields (valid from DECODE onward)
//   mem_ready           memory completes current access this cycle
//   IorD..RegWr         datapath controls (memory, IR, PC, ALU muxes, regfile)
//   instr_done          one-cycle pulse on an instruction's final cycle
//   illegal_op          one-cycle pulse in DECODE for unsupported Op/Funct
//   state               current state encoding, for debug
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemRd,
  output logic               MemWr,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IsBne,
  output logic [1:0]         PCSrc,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [2:0]         AluCtrl,
  output logic               SignExt,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWr,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 'd0,  FETCH  = 'd1,  DECODE = 'd2,  MEMADR = 'd3,
    MEMRD  = 'd4,  MEMWB  = 'd5,  MEMWR  = 'd6,  REXEC  = 'd7,
    RWB    = 'd8,  BRANCH = 'd9,  IEXEC  = 'd10, IWB    = 'd11,
    JUMP   = 'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;

  // R-type funct decode: ALU op plus a legality flag used by DECODE
  logic       r_ok;
  logic [2:0] r_ctrl;
  always_comb begin
    r_ok   = 1'b1;
    r_ctrl = ALU_ADD;
    case (Funct)
      6'b100000: r_ctrl = ALU_ADD;
      6'b100010: r_ctrl = ALU_SUB;
      6'b100100: r_ctrl = ALU_AND;
      6'b100101: r_ctrl = ALU_OR;
      6'b101010: r_ctrl = ALU_SLT;
      default:   r_ok   = 1'b0;
    endcase
  end

  // I-type ALU decode: logical immediates are zero-extended
  logic [2:0] i_ctrl;
  logic       i_sext;
  always_comb begin
    i_ctrl = ALU_ADD;
    i_sext = 1'b1;
    case (Op)
      OP_SLTI: i_ctrl = ALU_SLT;
      OP_ORI:  begin i_ctrl = ALU_OR;  i_sext = 1'b0; end
      OP_ANDI: begin i_ctrl = ALU_AND; i_sext = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    IorD        = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IsBne       = 1'b0;
    PCSrc       = 2'b00;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluCtrl     = ALU_ADD;
    SignExt     = 1'b1;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWr       = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      IDLE: begin
        // Same output image as reset: ALU code forced to zero too
        AluCtrl = 3'b000;
        state_d = FETCH;
      end
      FETCH: begin
        MemRd   = 1'b1;
        AluSrcB = 2'b01;              // PC + 4
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        AluSrcB = 2'b11;              // branch target precomputed into ALUOut
        case (Op)
          OP_LW, OP_SW:                       state_d = MEMADR;
          OP_BEQ, OP_BNE:                     state_d = BRANCH;
          OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI:  state_d = IEXEC;
          OP_J:                               state_d = JUMP;
          OP_R: begin
            if (r_ok) state_d = REXEC;
            else begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD  = 1'b1;
        MemRd = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        MemToReg   = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        IorD  = 1'b1;
        MemWr = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      REXEC: begin
        AluSrcA = 1'b1;
        AluCtrl = r_ctrl;
        state_d = RWB;
      end
      RWB: begin
        AluCtrl    = r_ctrl;
        RegDst     = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        AluSrcA     = 1'b1;
        AluCtrl     = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        IsBne       = (Op == OP_BNE);
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      IEXEC: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        AluCtrl = i_ctrl;
        SignExt = i_sext;
        state_d = IWB;
      end
      IWB: begin
        // ALU inputs held so the result stays stable during writeback
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        AluCtrl    = i_ctrl;
        SignExt    = i_sext;
        RegWr      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: begin
        AluCtrl = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule
